// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between two requesters.
// Read data is routed back to the issuing port exactly one cycle after acceptance.
module sram_arbiter #(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned N_ENTRIES = 1024,
  localparam int unsigned AW       = $clog2(N_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req_valid_0_i,
  output logic                req_ready_0_o,
  input  logic                req_we_0_i,
  input  logic [AW-1:0]       req_addr_0_i,
  input  logic [DATA_LEN-1:0] req_wdata_0_i,
  output logic                rsp_valid_0_o,
  output logic [DATA_LEN-1:0] rsp_rdata_0_o,

  input  logic                req_valid_1_i,
  output logic                req_ready_1_o,
  input  logic                req_we_1_i,
  input  logic [AW-1:0]       req_addr_1_i,
  input  logic [DATA_LEN-1:0] req_wdata_1_i,
  output logic                rsp_valid_1_o,
  output logic [DATA_LEN-1:0] rsp_rdata_1_o,

  output logic                sram_en_o,
  output logic                sram_we_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [DATA_LEN-1:0] sram_data_o,
  input  logic [DATA_LEN-1:0] sram_data_i
);

  logic last_grant_q, last_grant_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_port_q, rsp_port_d;

  logic gnt_valid;
  logic gnt_port;
  logic gnt_we;

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (rst_n) begin
      if (req_valid_0_i && req_valid_1_i) begin
        gnt_valid = 1'b1;
        gnt_port  = ~last_grant_q;
      end else if (req_valid_0_i) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end else if (req_valid_1_i) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_we        = gnt_port ? req_we_1_i : req_we_0_i;
    req_ready_0_o = gnt_valid & ~gnt_port;
    req_ready_1_o = gnt_valid & gnt_port;
    sram_en_o     = gnt_valid;
    sram_we_o     = gnt_valid & gnt_we;
    sram_addr_o   = '0;
    sram_data_o   = '0;
    if (gnt_valid) begin
      sram_addr_o = gnt_port ? req_addr_1_i : req_addr_0_i;
      sram_data_o = gnt_port ? req_wdata_1_i : req_wdata_0_i;
    end
  end

  always_comb begin
    last_grant_d = gnt_valid ? gnt_port : last_grant_q;
    rsp_pend_d   = gnt_valid & ~gnt_we;
    rsp_port_d   = (gnt_valid & ~gnt_we) ? gnt_port : rsp_port_q;
  end

  // Reset value 1 lets port 0 win the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_pend_q   <= 1'b0;
      rsp_port_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_port_q   <= rsp_port_d;
    end
  end

  always_comb begin
    rsp_valid_0_o = rst_n & rsp_pend_q & ~rsp_port_q;
    rsp_valid_1_o = rst_n & rsp_pend_q & rsp_port_q;
    rsp_rdata_0_o = rsp_valid_0_o ? sram_data_i : '0;
    rsp_rdata_1_o = rsp_valid_1_o ? sram_data_i : '0;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one single-port synchronous SRAM (registered read, 1-cycle latency, write-on-enable) between two masters inside the CFU, e.g. the CFU compute datapath (port 0) and the host/CPU loader path (port 1). It grants at most one access per cycle using round-robin fairness and drives the SRAM's enable, write-enable, address and write-data pins. It routes each read result back to the requester that issued it, exactly one cycle after acceptance.

## Interface
Parameters:
- DATA_LEN, 32, word width in bits.
- N_ENTRIES, 1024, SRAM depth in words; AW = $clog2(N_ENTRIES) is derived (localparam).

Ports (x = 0, 1; one set per requester):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_x_i  in  1  requester x presents an access.
- req_ready_x_o  out  1  access accepted this cycle (valid && ready = handshake).
- req_we_x_i  in  1  1 = write, 0 = read.
- req_addr_x_i  in  AW  word address.
- req_wdata_x_i  in  DATA_LEN  write data.
- rsp_valid_x_o  out  1  read data for requester x on rsp_rdata_x_o this cycle.
- rsp_rdata_x_o  out  DATA_LEN  read data; 0 when rsp_valid_x_o = 0.
- sram_en_o  out  1  SRAM enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AW  SRAM address.
- sram_data_o  out  DATA_LEN  SRAM write data.
- sram_data_i  in  DATA_LEN  SRAM registered read data.

## Operation
- State: last_grant (1 bit, port that won the most recent grant), rsp_pend (1 bit), rsp_port (1 bit).
- Grant, combinational each cycle:
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - Neither valid: no grant.
- req_ready_x_o = 1 only for the granted port. Ready does not depend on req_we. There is no stall source, so any lone valid is accepted the same cycle.
- On grant:
  - sram_en_o = 1.
  - sram_we_o = granted req_we.
  - sram_addr_o / sram_data_o = granted address / wdata.
- No grant: sram_en_o = 0, sram_we_o = 0. Addr/data are don't-care, driven 0.
- At a granted edge: last_grant <= granted port. It holds when there is no grant.
- Read granted: rsp_pend <= 1, rsp_port <= granted port. Otherwise rsp_pend <= 0.
- Response: rsp_valid_x_o = rsp_pend && (rsp_port == x). rsp_rdata_x_o = sram_data_i when rsp_valid_x_o, else 0.
- Writes produce no response.
- Requester rules:
  - A requester may change or drop its request when not ready; the arbiter keeps no request state.
  - Responses have no backpressure; the requester must take the data in that cycle.

## Timing
- Reset (rst_n low, asynchronously):
  - last_grant = 1, so port 0 wins the first contested cycle.
  - rsp_pend = 0, rsp_port = 0.
  - While rst_n is low, all req_ready_x_o, sram_en_o, sram_we_o and rsp_valid_x_o are forced to 0.
- Read latency: accepted in cycle T, so rsp_valid in cycle T+1 with the data, exactly one cycle wide.
- Back-to-back reads: one accepted per cycle gives one response per cycle. Responses are in order and can alternate ports each cycle.
- Continuous contention: grants alternate 0,1,0,1…; no port waits more than one cycle.
- Write at T then read of the same address at T+1 (either port): the read returns the new data.
- Read at T then write of the same address at T+1: the read returns the old data.
- A read and a write to the same address are never issued in one cycle.
- rst_n asserted while rsp_pend = 1: the response is dropped and not replayed after reset. A write accepted on the last edge before reset is already committed in the SRAM.
- Combinational paths: req_valid_* → req_ready_*, and req_* → sram_* (single mux level). Response outputs come only from registers plus sram_data_i.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF @0x010 in cycle 1 and reads @0x010 in cycle 2. Required: req_ready_0_o = 1 in both cycles; rsp_valid_0_o = 1 only in cycle 3 with rsp_rdata_0_o = 0xDEADBEEF; rsp_valid_1_o stays 0.
- After reset, both ports hold reads valid for 6 cycles (port 0 @0x001, port 1 @0x002, preloaded 0x11/0x22). Required:
  - grants alternate 0,1,0,1,0,1;
  - responses alternate rsp_valid_0/rsp_valid_1 one cycle later with 0x11/0x22;
  - the other port's rdata = 0 each cycle.
- Port 1 alone issues 4 consecutive reads @0x3FC..0x3FF (top addresses). Required: ready every cycle, 4 consecutive responses, last_grant stays 1, port 0 signals stay 0.
- Same cycle: port 0 writes 0xA5A5A5A5 @0x020 while port 1 reads @0x020 (old value 0x0), with last_grant = 1. Required:
  - cycle 1: the write is granted;
  - cycle 2: the read is granted;
  - cycle 3: the read returns 0xA5A5A5A5.
  - With last_grant = 0 instead, the read goes first and returns 0x0.
- Port 0 read accepted, then rst_n pulsed low mid-cycle before the response cycle. Required: all outputs go to 0 immediately, no rsp_valid after reset, and the first contested grant after reset goes to port 0.
